fifo_in_pack: RTL and testbench
===============================

Name: fifo_in_pack

Overview:
Input-side packer between the APB slave's 32-bit write data path and the AES-128 core.
Gathers four consecutive 32-bit words into one 128-bit block and stores completed blocks in a small block queue.
Presents blocks to the core with a valid/ready handshake.
Mirror of the output FIFO: the first word received occupies bits [127:96].

Parameters:
WORD_W, 32, width of one APB data word
WORDS_PER_BLOCK, 4, words per AES block (BLOCK_W = WORD_W*WORDS_PER_BLOCK = 128)
DEPTH, 2, number of complete 128-bit blocks the queue holds (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  reset, asynchronous, active-low
write_en  input  1  one-cycle strobe: data_in is a valid word
data_in  input  32  word from APB write data
clear  input  1  synchronous flush of all stored words and blocks
block_ready  input  1  AES core accepts block_out this cycle
block_valid  output  1  block_out holds a complete block
block_out  output  128  head-of-queue block
word_count  output  2  words held in the partial-assembly register (0..3)
fifo_empty  output  1  no partial words and no queued blocks
fifo_full  output  1  next write cannot be accepted
overflow_err  output  1  one-cycle pulse: write attempted while fifo_full

Behaviour:
- Reset (async, n_rst=0), all outputs immediately:
  - block_valid=0, block_out=0, word_count=0, fifo_empty=1, fifo_full=0, overflow_err=0.
  - All pointers, counts and storage cleared.
- Word packing: word k of a block (k=0..3) is written to bits [127-32k -: 32].
  - Words 0..2 are stored in the partial register; word_count increments.
- Block completion: 4th accepted word plus the three held words form one block.
  - The block is written to the queue at wr_ptr at the same edge; word_count returns to 0.
  - No intermediate cycle.
- Latency: 4th word sampled at edge N with an empty queue -> block_valid=1 and block_out valid after edge N (first-word-fall-through).
- Queue:
  - DEPTH entries; wr_ptr and rd_ptr wrap modulo DEPTH; qcount ranges 0..DEPTH.
  - block_valid = (qcount!=0); block_out = queue[rd_ptr].
- Pop: block_valid && block_ready at an edge -> rd_ptr+1, qcount-1.
  - block_ready while block_valid=0 is ignored.
- Accept: a write is accepted iff write_en && !fifo_full.
  - fifo_full = (word_count==3 && qcount==DEPTH), derived from registered state only.
  - Words 0..2 of a block are accepted even while the queue is full.
- Simultaneous push (block completion) and pop: qcount unchanged, both pointers advance.
- Write while full:
  - Word dropped; state unchanged.
  - overflow_err=1 for exactly the following cycle.
  - The same-cycle pop still occurs, but the dropped word is not retried.
- fifo_empty = (word_count==0 && qcount==0).
- clear:
  - Priority over write_en and block_ready.
  - Next edge: word_count=0, qcount=0, pointers=0, overflow_err=0.
  - Storage contents may persist, but block_valid=0 masks them.
- Reset mid-operation (including mid-block or block_valid=1): partial words and queued blocks are discarded; no residue after n_rst releases.
- No X propagation: block_out is driven from storage that is reset to 0.

Decomposition:
- Shared package aes_fifo_pkg:
  - WORD_W, BLOCK_W, WORDS_PER_BLOCK.
  - typedefs word_t (logic[31:0]) and block_t (logic[127:0]).
  - Shared with fifo_out.
- One sub-module, block_queue:
  - Parameterised DEPTH x BLOCK_W synchronous FIFO.
  - push, pop, clear, din, dout, count, valid.
  - Instantiated by fifo_in_pack, which owns the word packing, full/empty and error logic.

Test Plan:
1. Reset asserted, then released -> block_valid=0, block_out=0, word_count=0, fifo_empty=1, fifo_full=0, overflow_err=0.
2. Write 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with block_ready=0 -> word_count 1,2,3,0; block_valid=1 after the 4th edge; block_out=0x0011223344556677_8899AABBCCDDEEFF; fifo_empty=0.
3. Write 11 words with block_ready=0 -> fifo_full=1 after the 11th; the 12th write gives a one-cycle overflow_err=1, word_count stays 3, block_out unchanged; then one block_ready pulse -> fifo_full=0.
4. One block queued, block_ready=1 in the same cycle as the 4th word of block B -> qcount stays 1, next cycle block_out=B, block_valid=1.
5. Two words written, then clear=1 with write_en=1 -> word_count=0, fifo_empty=1, no word accepted; next 4 words form a clean block (no stale data).
6. n_rst pulsed low mid-block while block_valid=1 -> outputs take reset values immediately, without waiting for a clock; after release, 4 fresh words produce exactly one correct block.

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// rtl/aes_fifo_pkg.sv - shared word/block widths and types for the AES FIFOs
package aes_fifo_pkg;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/fifo_in_pack_if.sv
// rtl/fifo_in_pack_if.sv - word-in / block-out bundle of the input packer
interface fifo_in_pack_if;
  import aes_fifo_pkg::*;

  logic       write_en;
  word_t      data_in;
  logic       clear;
  logic       block_ready;
  logic       block_valid;
  block_t     block_out;
  logic [1:0] word_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow_err;

  modport master (
    output write_en, data_in, clear, block_ready,
    input  block_valid, block_out, word_count, fifo_empty, fifo_full, overflow_err
  );

  modport slave (
    input  write_en, data_in, clear, block_ready,
    output block_valid, block_out, word_count, fifo_empty, fifo_full, overflow_err
  );
endinterface

// File: rtl/block_queue.sv
// rtl/block_queue.sv - DEPTH x WIDTH synchronous FIFO, head visible on dout
module block_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         valid
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/fifo_in_pack.sv
// rtl/fifo_in_pack.sv - packs four 32-bit words (first word in the MSBs)
// into 128-bit blocks and queues them for the AES core.
module fifo_in_pack
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           n_rst,
  fifo_in_pack_if.slave bus
);
  localparam int            CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(DEPTH);

  logic [1:0]    word_count;
  word_t         held [WORDS_PER_BLOCK-1];
  logic [CW-1:0] qcount;
  logic          qvalid;
  block_t        qdout;
  logic          overflow_err;
  logic          full;
  logic          accept;
  logic          push;

  // Only the block-completing word can be refused; words 0..2 always fit.
  assign full   = (word_count == 2'd3) && (qcount == QFULL);
  assign accept = bus.write_en && !full;
  assign push   = accept && (word_count == 2'd3);

  block_queue #(
    .DEPTH (DEPTH),
    .WIDTH (BLOCK_W)
  ) u_queue (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (bus.block_ready),
    .clear (bus.clear),
    .din   ({held[0], held[1], held[2], bus.data_in}),
    .dout  (qdout),
    .count (qcount),
    .valid (qvalid)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_count   <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) held[i] <= '0;
    end else if (bus.clear) begin
      word_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= bus.write_en && full;
      if (accept) begin
        if (word_count == 2'd3) begin
          word_count <= '0;
        end else begin
          held[word_count] <= bus.data_in;
          word_count       <= word_count + 2'd1;
        end
      end
    end
  end

  assign bus.block_valid  = qvalid;
  assign bus.block_out    = qdout;
  assign bus.word_count   = word_count;
  assign bus.fifo_empty   = (word_count == 2'd0) && (qcount == '0);
  assign bus.fifo_full    = full;
  assign bus.overflow_err = overflow_err;
endmodule

// File: tb/tb_fifo_in_pack.sv
// tb/tb_fifo_in_pack.sv - self-checking bench for fifo_in_pack
module tb_fifo_in_pack;
  import aes_fifo_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fifo_in_pack_if bus();

  fifo_in_pack #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference: words waiting to form a block, and the list of whole blocks.
  word_t  m_words[$];
  block_t m_blocks[$];
  logic   m_ovf;

  task automatic cycle(input logic we, input word_t d, input logic clr, input logic rdy);
    logic full;
    bus.write_en    = we;
    bus.data_in     = d;
    bus.clear       = clr;
    bus.block_ready = rdy;
    full = (m_words.size() == 3) && (m_blocks.size() == DEPTH);
    if (clr) begin
      m_words.delete();
      m_blocks.delete();
      m_ovf = 1'b0;
    end else begin
      m_ovf = we && full;
      if (rdy && m_blocks.size() != 0) void'(m_blocks.pop_front());
      if (we && !full) begin
        m_words.push_back(d);
        if (m_words.size() == WORDS_PER_BLOCK) begin
          m_blocks.push_back({m_words[0], m_words[1], m_words[2], m_words[3]});
          m_words.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    bus.write_en    = 1'b0;
    bus.clear       = 1'b0;
    bus.block_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus.write_en    = 1'b0;
    bus.data_in     = '0;
    bus.clear       = 1'b0;
    bus.block_ready = 1'b0;
    n_rst = 1'b0;
    m_words.delete();
    m_blocks.delete();
    m_ovf = 1'b0;
    #12;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.block_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.block_valid); else passed++;
    checks++; if (bus.block_out !== '0) $display("FAIL reset_out: got %h want 0", bus.block_out); else passed++;
    checks++; if (bus.word_count !== 2'd0) $display("FAIL reset_wc: got %0d want 0", bus.word_count); else passed++;
    checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); else passed++;
    checks++; if (bus.fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.fifo_full); else passed++;
    checks++; if (bus.overflow_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.overflow_err); else passed++;
  endtask

  task automatic test_pack();
    word_t w[4];
    w[0] = 32'h00112233; w[1] = 32'h44556677; w[2] = 32'h8899AABB; w[3] = 32'hCCDDEEFF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, w[i], 1'b0, 1'b0);
      checks++;
      if (bus.word_count !== 2'((i + 1) % 4))
        $display("FAIL pack_wc%0d: got %0d want %0d", i, bus.word_count, (i + 1) % 4);
      else passed++;
      if (i < 3) begin
        checks++; if (bus.block_valid !== 1'b0) $display("FAIL pack_early_valid%0d: got %b want 0", i, bus.block_valid); else passed++;
      end
    end
    checks++; if (bus.block_valid !== 1'b1) $display("FAIL pack_valid: got %b want 1", bus.block_valid); else passed++;
    checks++;
    if (bus.block_out !== 128'h00112233445566778899AABBCCDDEEFF)
      $display("FAIL pack_out: got %h want 00112233445566778899aabbccddeeff", bus.block_out);
    else passed++;
    checks++; if (bus.fifo_empty !== 1'b0) $display("FAIL pack_empty: got %b want 0", bus.fifo_empty); else passed++;
  endtask

  task automatic test_full_overflow();
    block_t head;
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (bus.fifo_full !== 1'b1) $display("FAIL full_set: got %b want 1", bus.fifo_full); else passed++;
    head = m_blocks[0];
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (bus.overflow_err !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", bus.overflow_err); else passed++;
    checks++; if (bus.word_count !== 2'd3) $display("FAIL ovf_wc: got %0d want 3", bus.word_count); else passed++;
    checks++; if (bus.block_out !== head) $display("FAIL ovf_out: got %h want %h", bus.block_out, head); else passed++;
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (bus.overflow_err !== 1'b0) $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow_err); else passed++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.fifo_full !== 1'b0) $display("FAIL full_clear_on_pop: got %b want 0", bus.fifo_full); else passed++;
    checks++; if (bus.block_out !== m_blocks[0]) $display("FAIL pop_next_head: got %h want %h", bus.block_out, m_blocks[0]); else passed++;
  endtask

  task automatic test_push_pop();
    word_t  b[4];
    block_t exp_b;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) b[i] = $urandom;
    exp_b = {b[0], b[1], b[2], b[3]};
    for (int i = 0; i < 3; i++) cycle(1'b1, b[i], 1'b0, 1'b0);
    cycle(1'b1, b[3], 1'b0, 1'b1);
    checks++; if (bus.block_valid !== 1'b1) $display("FAIL pp_valid: got %b want 1", bus.block_valid); else passed++;
    checks++; if (bus.block_out !== exp_b) $display("FAIL pp_out: got %h want %h", bus.block_out, exp_b); else passed++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL pp_single_block: got %b want 1", bus.fifo_empty); else passed++;
  endtask

  task automatic test_clear();
    word_t  w[4];
    block_t exp_b;
    do_reset();
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    cycle(1'b1, 32'h12345678, 1'b1, 1'b0);
    checks++; if (bus.word_count !== 2'd0) $display("FAIL clr_wc: got %0d want 0", bus.word_count); else passed++;
    checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL clr_empty: got %b want 1", bus.fifo_empty); else passed++;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      cycle(1'b1, w[i], 1'b0, 1'b0);
    end
    exp_b = {w[0], w[1], w[2], w[3]};
    checks++; if (bus.block_out !== exp_b) $display("FAIL clr_clean_block: got %h want %h", bus.block_out, exp_b); else passed++;
    checks++; if (bus.block_valid !== 1'b1) $display("FAIL clr_valid: got %b want 1", bus.block_valid); else passed++;
  endtask

  task automatic test_async_reset();
    word_t  w[4];
    block_t exp_b;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    checks++; if (bus.block_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b want 1", bus.block_valid); else passed++;
    #1;
    n_rst = 1'b0;
    #1;
    m_words.delete();
    m_blocks.delete();
    m_ovf = 1'b0;
    checks++; if (bus.block_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", bus.block_valid); else passed++;
    checks++; if (bus.block_out !== '0) $display("FAIL ar_out: got %h want 0", bus.block_out); else passed++;
    checks++; if (bus.word_count !== 2'd0) $display("FAIL ar_wc: got %0d want 0", bus.word_count); else passed++;
    checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL ar_empty: got %b want 1", bus.fifo_empty); else passed++;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      cycle(1'b1, w[i], 1'b0, 1'b0);
    end
    exp_b = {w[0], w[1], w[2], w[3]};
    checks++; if (bus.block_out !== exp_b) $display("FAIL ar_fresh_block: got %h want %h", bus.block_out, exp_b); else passed++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.block_valid !== 1'b0) $display("FAIL ar_one_block: got %b want 0", bus.block_valid); else passed++;
  endtask

  task automatic test_random();
    logic we, clr, rdy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 99) < 25);
      cycle(we, $urandom, clr, rdy);
      checks++;
      if (bus.word_count !== 2'(m_words.size()))
        $display("FAIL rnd_wc@%0d: got %0d want %0d", n, bus.word_count, m_words.size());
      else passed++;
      checks++;
      if (bus.block_valid !== (m_blocks.size() != 0))
        $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.block_valid, m_blocks.size() != 0);
      else passed++;
      checks++;
      if (bus.fifo_full !== ((m_words.size() == 3) && (m_blocks.size() == DEPTH)))
        $display("FAIL rnd_full@%0d: got %b", n, bus.fifo_full);
      else passed++;
      checks++;
      if (bus.fifo_empty !== ((m_words.size() == 0) && (m_blocks.size() == 0)))
        $display("FAIL rnd_empty@%0d: got %b", n, bus.fifo_empty);
      else passed++;
      checks++;
      if (bus.overflow_err !== m_ovf)
        $display("FAIL rnd_ovf@%0d: got %b want %b", n, bus.overflow_err, m_ovf);
      else passed++;
      if (m_blocks.size() != 0) begin
        checks++;
        if (bus.block_out !== m_blocks[0])
          $display("FAIL rnd_out@%0d: got %h want %h", n, bus.block_out, m_blocks[0]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_full_overflow();
    test_push_pop();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
